// File: rtl/ram_copy_master_if.sv
// Avalon-MM bus between the copy master and the on-chip single-port RAM.
// Zero latency: a plain bundle of wires with no storage of its own.
// No backpressure: the RAM has no waitrequest and returns readdata one cycle after a read.
//
// master modport: address, byteenable, chipselect, write, writedata, clken out; readdata in.
// slave  modport: the same signals with directions reversed.
interface ram_copy_master_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic                    clken;
  logic [DATA_WIDTH-1:0]   readdata;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/ram_copy_master.sv
// Copies a block of words from one RAM region to another and keeps a running checksum of them.
// Latency: 3 cycles per word (read, capture, write); done pulses 3*length+1 cycles after the accepted start.
// No backpressure: the RAM never stalls; start is ignored unless the engine is idle.
//
// Ports: clk, reset (async, active-high);
//        start/src_addr/dst_addr/length: request, latched when start is accepted in idle;
//        busy/done/checksum: status back to the control register block;
//        bus: Avalon-MM master port to the RAM (all outputs registered).
module ram_copy_master #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum,
  ram_copy_master_if.master     bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_DONE
  } state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] src_ptr, src_ptr_d;
  logic [ADDR_WIDTH-1:0] dst_ptr, dst_ptr_d;
  logic [LEN_WIDTH-1:0]  remaining, remaining_d;
  logic [DATA_WIDTH-1:0] data_buf, data_buf_d;
  logic [DATA_WIDTH-1:0] checksum_d;

  // Next values of the registered bus and status outputs.
  logic [ADDR_WIDTH-1:0] address_d;
  logic                  chipselect_d;
  logic                  write_d;
  logic [DATA_WIDTH-1:0] writedata_d;
  logic                  busy_d;
  logic                  done_d;

  // The RAM is always byte-complete and always clocked.
  assign bus.byteenable = '1;
  assign bus.clken      = 1'b1;

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state;
    src_ptr_d   = src_ptr;
    dst_ptr_d   = dst_ptr;
    remaining_d = remaining;
    data_buf_d  = data_buf;
    checksum_d  = checksum;

    case (state)
      ST_IDLE: begin
        if (start) begin
          src_ptr_d   = src_addr;
          dst_ptr_d   = dst_addr;
          remaining_d = length;
          checksum_d  = '0;
          state_d     = (length == '0) ? ST_DONE : ST_RD;
        end
      end
      ST_RD: begin
        state_d = ST_CAP;
      end
      ST_CAP: begin
        // readdata belongs to the read issued in the previous cycle.
        data_buf_d = bus.readdata;
        checksum_d = checksum + bus.readdata;
        state_d    = ST_WR;
      end
      ST_WR: begin
        // Pointers wrap naturally at the top of the address space.
        src_ptr_d   = src_ptr + 1'b1;
        dst_ptr_d   = dst_ptr + 1'b1;
        remaining_d = remaining - 1'b1;
        state_d     = (remaining == LEN_WIDTH'(1)) ? ST_DONE : ST_RD;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus outputs are registered, so they are derived from the state being entered:
  // RD drives the (possibly just incremented) source pointer, WR drives the
  // destination pointer with the word captured in CAP.
  always_comb begin
    chipselect_d = (state_d == ST_RD) || (state_d == ST_WR);
    write_d      = (state_d == ST_WR);
    address_d    = bus.address;
    writedata_d  = bus.writedata;
    if (state_d == ST_RD) begin
      address_d = src_ptr_d;
    end else if (state_d == ST_WR) begin
      address_d   = dst_ptr_d;
      writedata_d = data_buf_d;
    end
    busy_d = (state_d == ST_RD) || (state_d == ST_CAP) || (state_d == ST_WR);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      src_ptr        <= '0;
      dst_ptr        <= '0;
      remaining      <= '0;
      data_buf       <= '0;
      checksum       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.address    <= '0;
      bus.chipselect <= 1'b0;
      bus.write      <= 1'b0;
      bus.writedata  <= '0;
    end else begin
      state          <= state_d;
      src_ptr        <= src_ptr_d;
      dst_ptr        <= dst_ptr_d;
      remaining      <= remaining_d;
      data_buf       <= data_buf_d;
      checksum       <= checksum_d;
      busy           <= busy_d;
      done           <= done_d;
      bus.address    <= address_d;
      bus.chipselect <= chipselect_d;
      bus.write      <= write_d;
      bus.writedata  <= writedata_d;
    end
  end

endmodule

// File: tb/tb_ram_copy_master.sv
// Bench for ram_copy_master: behavioural RAM on the bus, array-based reference copy model.
// Each transfer is checked for latency, done/busy/chipselect counts, bus protocol, checksum and RAM contents.
// The RAM never stalls, so there is no backpressure to exercise.
module tb_ram_copy_master;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int LW    = 13;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  ram_copy_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

  ram_copy_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .checksum (checksum),
    .bus      (ifc)
  );

  always #5 clk = ~clk;

  // RAM contents as seen by the DUT, and the expected contents.
  logic [DW-1:0] mem     [WORDS];
  logic [DW-1:0] exp_mem [WORDS];

  // Single-port RAM, 1-cycle read latency.
  always @(posedge clk) begin
    if (ifc.chipselect) begin
      if (ifc.write) mem[ifc.address] <= ifc.writedata;
      else           ifc.readdata     <= mem[ifc.address];
    end
  end

  // Monitor: running counters, sampled on the falling edge.
  int cyc       = 0;
  int busy_cnt  = 0;
  int done_cnt  = 0;
  int cs_cnt    = 0;
  int viol_cnt  = 0;
  int last_done = -1;
  bit rd1 = 1'b0;
  bit rd2 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      last_done = cyc;
    end
    if (ifc.chipselect === 1'b1) cs_cnt++;
    // A write must follow a read two cycles earlier.
    if (ifc.chipselect === 1'b1 && ifc.write === 1'b1 && !rd2) viol_cnt++;
    // Nothing selected in the capture cycle right after a read.
    if (ifc.chipselect === 1'b1 && rd1) viol_cnt++;
    // Nothing selected while idle or signalling done.
    if (ifc.chipselect === 1'b1 && busy !== 1'b1) viol_cnt++;
    if (ifc.byteenable !== 4'hF || ifc.clken !== 1'b1) viol_cnt++;
    rd2 = rd1;
    rd1 = (ifc.chipselect === 1'b1) && (ifc.write === 1'b0);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference copy: ascending order, one word at a time, addresses modulo the RAM size.
  function automatic logic [DW-1:0] model_copy(input int s_a, input int d_a, input int ln);
    logic [DW-1:0] sum = '0;
    logic [DW-1:0] v;
    for (int i = 0; i < ln; i++) begin
      v = exp_mem[(s_a + i) % WORDS];
      exp_mem[(d_a + i) % WORDS] = v;
      sum += v;
    end
    return sum;
  endfunction

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < WORDS; i++)
      if (mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  task automatic poke_mem(input int a, input logic [DW-1:0] v);
    mem[a]     = v;
    exp_mem[a] = v;
  endtask

  // One full transfer; with 'retrigger' set, a conflicting start is pulsed mid-transfer.
  task automatic run_copy(input string tag, input int s_a, input int d_a, input int ln,
                          input bit retrigger);
    int b0, d0, c0, v0, s, k;
    logic [DW-1:0] esum;
    @(negedge clk); #1;
    b0 = busy_cnt; d0 = done_cnt; c0 = cs_cnt; v0 = viol_cnt; s = cyc;
    src_addr = AW'(s_a);
    dst_addr = AW'(d_a);
    length   = LW'(ln);
    start    = 1'b1;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
      start = 1'b0;
      if (retrigger && k == 4) begin
        src_addr = ~src_addr;
        dst_addr = ~dst_addr;
        length   = 13'd7;
        start    = 1'b1;
      end
    end while (done_cnt == d0 && k < 3 * ln + 20);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    esum = model_copy(s_a, d_a, ln);
    check({tag, ".latency"}, 64'(last_done - s), 64'(3 * ln + 1));
    check({tag, ".done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({tag, ".busy_cycles"}, 64'(busy_cnt - b0), 64'(3 * ln));
    check({tag, ".cs_cycles"}, 64'(cs_cnt - c0), 64'(2 * ln));
    check({tag, ".protocol"}, 64'(viol_cnt - v0), 64'd0);
    check({tag, ".checksum"}, 64'(checksum), 64'(esum));
    check({tag, ".ram_diffs"}, 64'(mem_diffs()), 64'd0);
  endtask

  initial begin
    int s_a, d_a, ln;
    reset    = 1'b1;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length   = '0;
    for (int i = 0; i < WORDS; i++) poke_mem(i, $urandom);
    repeat (3) @(negedge clk);

    // Reset state.
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.checksum", 64'(checksum), 64'd0);
    check("reset.address", 64'(ifc.address), 64'd0);
    check("reset.chipselect", 64'(ifc.chipselect), 64'd0);
    check("reset.write", 64'(ifc.write), 64'd0);
    check("reset.writedata", 64'(ifc.writedata), 64'd0);
    check("reset.byteenable", 64'(ifc.byteenable), 64'hF);
    check("reset.clken", 64'(ifc.clken), 64'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic 4-word copy.
    poke_mem(0, 32'h11111111);
    poke_mem(1, 32'h22222222);
    poke_mem(2, 32'h33333333);
    poke_mem(3, 32'h44444444);
    run_copy("basic", 0, 100, 4, 1'b0);
    check("basic.checksum_const", 64'(checksum), 64'hAAAAAAAA);

    // Zero length.
    run_copy("len0", 5, 200, 0, 1'b0);
    check("len0.checksum_const", 64'(checksum), 64'd0);

    // Source wraps past the top of the RAM.
    poke_mem(4094, 32'd1);
    poke_mem(4095, 32'd2);
    poke_mem(0, 32'd3);
    poke_mem(1, 32'd4);
    run_copy("src_wrap", 4094, 10, 4, 1'b0);
    check("src_wrap.checksum_const", 64'(checksum), 64'd10);

    // Destination wraps.
    run_copy("dst_wrap", 50, 4095, 2, 1'b0);

    // Checksum overflow.
    poke_mem(300, 32'hFFFFFFFF);
    poke_mem(301, 32'h00000002);
    run_copy("overflow", 300, 400, 2, 1'b0);
    check("overflow.checksum_const", 64'(checksum), 64'd1);

    // Start while busy is ignored.
    run_copy("retrigger", 20, 60, 6, 1'b1);

    // Forward overlap propagates earlier words.
    run_copy("overlap", 500, 502, 8, 1'b0);

    // Random transfers.
    for (int r = 0; r < 6; r++) begin
      s_a = $urandom_range(0, WORDS - 1);
      d_a = $urandom_range(0, WORDS - 1);
      ln  = $urandom_range(1, 30);
      run_copy($sformatf("rand%0d", r), s_a, d_a, ln, 1'b0);
    end

    // Whole RAM with wrap.
    run_copy("full", 0, 100, 4096, 1'b0);

    // Reset during the write of word index 2 of a 5-word copy.
    for (int i = 0; i < 5; i++) poke_mem(700 + i, $urandom);
    @(negedge clk); #1;
    src_addr = AW'(700);
    dst_addr = AW'(800);
    length   = LW'(5);
    start    = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("rst_mid.pre_write", 64'(ifc.write), 64'd1);
    check("rst_mid.pre_address", 64'(ifc.address), 64'd802);
    reset = 1'b1;
    #1;
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    check("rst_mid.checksum", 64'(checksum), 64'd0);
    check("rst_mid.address", 64'(ifc.address), 64'd0);
    check("rst_mid.chipselect", 64'(ifc.chipselect), 64'd0);
    check("rst_mid.write", 64'(ifc.write), 64'd0);
    check("rst_mid.writedata", 64'(ifc.writedata), 64'd0);
    void'(model_copy(700, 800, 2));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid.ram_diffs", 64'(mem_diffs()), 64'd0);
    run_copy("after_rst", 700, 800, 5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
